// File: rtl/dense_pkg.sv
// Shared types and elaboration-time helpers for the dense-layer lane serializer.
// Per-lane width/shift tables are packed 8 bits per lane, lane 0 at the LSBs.
package dense_pkg;

  localparam int MAX_LANES = 256;
  localparam int TABLE_W   = 8 * MAX_LANES;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Bit offset of lane i inside the packed input frame.
  function automatic int lane_offset(input logic [TABLE_W-1:0] widths, input int i);
    int off;
    off = 0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < i) off += int'(widths[8*k +: 8]);
    end
    return off;
  endfunction

  function automatic int sum_widths(input logic [TABLE_W-1:0] widths, input int n);
    return lane_offset(widths, n);
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dense_lane_align.sv
// Aligns one lane to the common fixed-point format: extend to LANE_W, then
// shift left to restore the LSBs the core dropped. Pure wiring.
module dense_lane_align #(
  parameter int WIDTH  = 8,
  parameter int SHIFT  = 0,
  parameter int LANE_W = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0]  lane_in,
  output logic [LANE_W-1:0] lane_out
);

  logic [LANE_W-1:0] ext;

  if (SIGNED) begin : g_sext
    assign ext = LANE_W'(signed'(lane_in));
  end else begin : g_zext
    assign ext = LANE_W'(lane_in);
  end

  assign lane_out = ext << SHIFT;

endmodule

// File: rtl/dense_lane_serializer.sv
// Captures one packed variable-width result frame, aligns every lane and
// streams the lanes out as fixed-size beats over a valid/ready bus.
module dense_lane_serializer
  import dense_pkg::*;
#(
  parameter int                   N_LANES        = 32,
  parameter int                   LANE_W         = 47,
  parameter int                   LANES_PER_BEAT = 4,
  parameter logic [8*N_LANES-1:0] LANE_WIDTHS    = {32{8'd43}},
  parameter logic [8*N_LANES-1:0] LANE_SHIFTS    = {32{8'd4}},
  parameter bit                   SIGNED         = 1'b1,
  localparam int IN_W       = sum_widths(TABLE_W'(LANE_WIDTHS), N_LANES),
  localparam int NUM_BEATS  = (LANES_PER_BEAT > 0) ?
                              (N_LANES + LANES_PER_BEAT - 1) / LANES_PER_BEAT : 1,
  localparam int BEAT_IDX_W = (clog2(NUM_BEATS) > 0) ? clog2(NUM_BEATS) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_W-1:0]                    in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES_PER_BEAT*LANE_W-1:0]   out_data,
  output logic                               out_last,
  output logic [BEAT_IDX_W-1:0]              out_beat
);

  localparam int BEAT_W  = LANES_PER_BEAT * LANE_W;
  localparam int FRAME_W = N_LANES * LANE_W;
  localparam int PAD_W   = NUM_BEATS * BEAT_W;
  localparam logic [TABLE_W-1:0] WIDTHS_T = TABLE_W'(LANE_WIDTHS);
  localparam logic [TABLE_W-1:0] SHIFTS_T = TABLE_W'(LANE_SHIFTS);

  if (LANES_PER_BEAT == 0) begin : g_bad_lpb
    $error("LANES_PER_BEAT must be non-zero");
  end
  if (N_LANES == 0 || N_LANES > MAX_LANES) begin : g_bad_lanes
    $error("N_LANES=%0d outside 1..%0d", N_LANES, MAX_LANES);
  end

  logic [FRAME_W-1:0]    aligned;
  logic [FRAME_W-1:0]    frame_q;
  logic [PAD_W-1:0]      padded;
  logic [BEAT_IDX_W-1:0] beat_idx, beat_d;
  state_e                state_q, state_d;
  logic                  load;
  logic                  is_last;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    localparam int W   = int'(WIDTHS_T[8*i +: 8]);
    localparam int S   = int'(SHIFTS_T[8*i +: 8]);
    localparam int OFF = lane_offset(WIDTHS_T, i);
    if (W == 0 || W + S > LANE_W) begin : g_bad
      $error("lane %0d: width %0d shift %0d does not fit LANE_W %0d", i, W, S, LANE_W);
    end else begin : g_ok
      dense_lane_align #(
        .WIDTH (W),
        .SHIFT (S),
        .LANE_W(LANE_W),
        .SIGNED(SIGNED)
      ) u_align (
        .lane_in (in_data[OFF +: W]),
        .lane_out(aligned[i*LANE_W +: LANE_W])
      );
    end
  end

  // Lanes past N_LANES in the final beat read as zero via the padding.
  assign padded  = PAD_W'(frame_q);
  assign is_last = (beat_idx == BEAT_IDX_W'(NUM_BEATS - 1));

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_idx;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          beat_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (!is_last) begin
            beat_d = beat_idx + BEAT_IDX_W'(1);
          end else begin
            in_ready = 1'b1;
            beat_d   = '0;
            if (in_valid) load    = 1'b1;
            else          state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (state_q == ST_SEND) out_data = padded[int'(beat_idx)*BEAT_W +: BEAT_W];
  end

  assign out_last = (state_q == ST_SEND) && is_last;
  assign out_beat = beat_idx;

  // NOTE: state uses non-blocking assignments; the frame buffer is reset too,
  // so out_data is defined as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      beat_idx <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_idx <= beat_d;
      if (load) frame_q <= aligned;
    end
  end

endmodule

// File: tb/tb_dense_lane_serializer.sv
// Scoreboard bench: a signed and an unsigned build share stimulus; expected
// beats are queued on frame accept and popped by per-build monitors.
module tb_dense_lane_serializer;

  localparam int N_LANES = 4;
  localparam int LANE_W  = 8;
  localparam int LPB     = 3;
  localparam logic [31:0] WIDTHS = {8'd3, 8'd6, 8'd5, 8'd4};
  localparam logic [31:0] SHIFTS = {8'd3, 8'd0, 8'd1, 8'd2};

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        beat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [17:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        s_in_ready, s_out_valid, s_out_last;
  logic [23:0] s_out_data;
  logic [0:0]  s_out_beat;
  logic        u_in_ready, u_out_valid, u_out_last;
  logic [23:0] u_out_data;
  logic [0:0]  u_out_beat;

  exp_t q_s[$];
  exp_t q_u[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dense_lane_serializer #(
    .N_LANES(N_LANES), .LANE_W(LANE_W), .LANES_PER_BEAT(LPB),
    .LANE_WIDTHS(WIDTHS), .LANE_SHIFTS(SHIFTS), .SIGNED(1'b1)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_last(s_out_last), .out_beat(s_out_beat)
  );

  dense_lane_serializer #(
    .N_LANES(N_LANES), .LANE_W(LANE_W), .LANES_PER_BEAT(LPB),
    .LANE_WIDTHS(WIDTHS), .LANE_SHIFTS(SHIFTS), .SIGNED(1'b0)
  ) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(in_data), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .out_last(u_out_last), .out_beat(u_out_beat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: compare every handshaken beat against the head of its queue.
  always @(negedge clk) begin
    if (rst_n && s_out_valid && out_ready) begin
      if (q_s.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL s_unexpected_beat: got data %h, expected no beat", s_out_data);
      end else begin
        exp_t e;
        e = q_s.pop_front();
        check("s_data", 64'(s_out_data), 64'(e.data));
        check("s_last", 64'(s_out_last), 64'(e.last));
        check("s_beat", 64'(s_out_beat), 64'(e.beat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && u_out_valid && out_ready) begin
      if (q_u.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL u_unexpected_beat: got data %h, expected no beat", u_out_data);
      end else begin
        exp_t e;
        e = q_u.pop_front();
        check("u_data", 64'(u_out_data), 64'(e.data));
        check("u_last", 64'(u_out_last), 64'(e.last));
        check("u_beat", 64'(u_out_beat), 64'(e.beat));
      end
    end
  end

  // Presents a frame, waits (bounded) for acceptance, queues expected beats.
  task automatic send_frame(input logic [17:0] d,
                            input logic [23:0] s0, input logic [23:0] s1,
                            input logic [23:0] u0, input logic [23:0] u1,
                            input bit hold);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: frame %h not accepted within 50 cycles", d);
    end else begin
      check("u_in_ready_at_accept", 64'(u_in_ready), 64'd1);
      q_s.push_back('{data: s0, last: 1'b0, beat: 1'b0});
      q_s.push_back('{data: s1, last: 1'b1, beat: 1'b1});
      q_u.push_back('{data: u0, last: 1'b0, beat: 1'b0});
      q_u.push_back('{data: u1, last: 1'b1, beat: 1'b1});
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_in_ready",  64'(s_in_ready),  64'd1);
    check("rst_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_out_data",  64'(s_out_data),  64'd0);
    check("rst_out_last",  64'(s_out_last),  64'd0);
    check("rst_out_beat",  64'(s_out_beat),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame with out_ready held high
    out_ready = 1'b1;
    send_frame(18'h1C0F9, 24'hE01EE4, 24'h000018, 24'h201E24, 24'h000018, 1'b0);
    repeat (3) @(negedge clk);
    check("single_idle_valid", 64'(s_out_valid), 64'd0);
    check("single_idle_ready", 64'(s_in_ready),  64'd1);

    // Backpressure: beat 0 must hold for four stalled cycles
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_frame(18'h1C0F9, 24'hE01EE4, 24'h000018, 24'h201E24, 24'h000018, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("bp_s_valid",    64'(s_out_valid), 64'd1);
      check("bp_s_data",     64'(s_out_data),  64'hE01EE4);
      check("bp_u_data",     64'(u_out_data),  64'h201E24);
      check("bp_s_beat",     64'(s_out_beat),  64'd0);
      check("bp_s_in_ready", 64'(s_in_ready),  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_beat1_next", 64'(s_out_beat), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back: second frame accepted on the last-beat handshake
    send_frame(18'h1C0F9, 24'hE01EE4, 24'h000018, 24'h201E24, 24'h000018, 1'b1);
    in_data = 18'h00000;
    send_frame(18'h00000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b0);
    @(negedge clk);
    check("b2b_no_bubble_valid", 64'(s_out_valid), 64'd1);
    check("b2b_no_bubble_beat",  64'(s_out_beat),  64'd0);
    check("b2b_no_bubble_data",  64'(s_out_data),  64'd0);
    repeat (2) @(negedge clk);
    check("b2b_end_idle", 64'(s_out_valid), 64'd0);

    // Asynchronous reset while beat 0 stalls
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_frame(18'h1C0F9, 24'hE01EE4, 24'h000018, 24'h201E24, 24'h000018, 1'b0);
    @(negedge clk);
    check("mid_valid_before_rst", 64'(s_out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_valid", 64'(s_out_valid), 64'd0);
    check("mid_rst_s_last",  64'(s_out_last),  64'd0);
    check("mid_rst_s_data",  64'(s_out_data),  64'd0);
    check("mid_rst_u_data",  64'(u_out_data),  64'd0);
    check("mid_rst_ready",   64'(s_in_ready),  64'd1);
    q_s.delete();
    q_u.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(s_in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_frame(18'h1C0F9, 24'hE01EE4, 24'h000018, 24'h201E24, 24'h000018, 1'b0);
    repeat (4) @(negedge clk);

    check("s_queue_drained", 64'(q_s.size()), 64'd0);
    check("u_queue_drained", 64'(q_u.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
